alu_seq: RTL and testbench

Parametrised, registered successor to the team's 3-bit combinational ALU. It keeps the same four opcodes (XNOR, shift, add, multiply) and adds the following:
- generic operand width WIDTH;
- valid/ready handshakes on input and output;
- a multi-cycle shift-add multiplier.
It sits between the operand/opcode source and the result consumer in the datapath. Either side may stall.

---
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU (XNOR, shift, add, multiply) with valid/ready handshakes on both sides.
// Define ALU_SEQ_FAST_MUL_EN for a single-cycle multiplier; otherwise a WIDTH-cycle shift-add is used.
module alu_seq #(
  parameter int WIDTH = 3,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           ALU_OP,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Dout,
  output logic                 zero,
  output logic                 busy
);

  localparam int RW = 2 * WIDTH;

`ifdef ALU_SEQ_FAST_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

  // Single-cycle opcodes; in the default build opcode 11 is handled by the MUL state instead.
  function automatic logic [RW-1:0] alu_result(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [RW-1:0] r;
    case (op)
      2'b00:   r = {{WIDTH{1'b0}}, ~(a ^ b)};
      2'b01:   r = {b[WIDTH-2:0], a, 1'b0};
      2'b10:   r = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
`ifdef ALU_SEQ_FAST_MUL_EN
      2'b11:   r = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif
      default: r = {RW{1'b0}};
    endcase
    return r;
  endfunction

  state_t            state_r, state_s;
  logic [RW-1:0]     dout_r, dout_s;
  logic              zero_r, zero_s;
  logic [RW-1:0]     op_res_s;

`ifndef ALU_SEQ_FAST_MUL_EN
  logic [RW-1:0]     acc_r, acc_s, acc_step_s;
  logic [RW-1:0]     mcand_r, mcand_s;
  logic [WIDTH-1:0]  mplier_r, mplier_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
`endif

  assign op_res_s = alu_result(ALU_OP, A, B);

  // Next-state and datapath update for the IDLE/MUL/DONE controller.
  always_comb begin
    state_s = state_r;
    dout_s  = dout_r;
    zero_s  = zero_r;
`ifndef ALU_SEQ_FAST_MUL_EN
    acc_s      = acc_r;
    mcand_s    = mcand_r;
    mplier_s   = mplier_r;
    cnt_s      = cnt_r;
    acc_step_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
`endif
    case (state_r)
      IDLE: begin
`ifndef ALU_SEQ_FAST_MUL_EN
        if (in_valid && (ALU_OP == 2'b11)) begin
          state_s  = MUL;
          acc_s    = {RW{1'b0}};
          mcand_s  = {{WIDTH{1'b0}}, A};
          mplier_s = B;
          cnt_s    = {CNT_W{1'b0}};
        end else
`endif
        if (in_valid) begin
          state_s = DONE;
          dout_s  = op_res_s;
          zero_s  = (op_res_s == {RW{1'b0}});
        end else begin
          state_s = IDLE;
        end
      end
`ifndef ALU_SEQ_FAST_MUL_EN
      MUL: begin
        // The final iteration's sum goes straight to Dout so DONE follows after exactly WIDTH MUL cycles.
        acc_s    = acc_step_s;
        mcand_s  = {mcand_r[RW-2:0], 1'b0};
        mplier_s = {1'b0, mplier_r[WIDTH-1:1]};
        cnt_s    = cnt_r + CNT_W'(1);
        if (cnt_r == LAST_CNT) begin
          state_s = DONE;
          dout_s  = acc_step_s;
          zero_s  = (acc_step_s == {RW{1'b0}});
        end else begin
          state_s = MUL;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      dout_r   <= {RW{1'b0}};
      zero_r   <= 1'b0;
`ifndef ALU_SEQ_FAST_MUL_EN
      acc_r    <= {RW{1'b0}};
      mcand_r  <= {RW{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
`endif
    end else begin
      state_r  <= state_s;
      dout_r   <= dout_s;
      zero_r   <= zero_s;
`ifndef ALU_SEQ_FAST_MUL_EN
      acc_r    <= acc_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      cnt_r    <= cnt_s;
`endif
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign Dout      = dout_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed WIDTH=3 scenarios and a randomized WIDTH=8 sweep
// against an arithmetic reference model with an in-order scoreboard.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;

`ifdef ALU_SEQ_FAST_MUL_EN
  localparam int MUL_LAT3 = 1;
`else
  localparam int MUL_LAT3 = 4;
`endif

  logic       iv3_s, ir3_s, ov3_s, or3_s, z3_s, busy3_s;
  logic [1:0] op3_s;
  logic [2:0] a3_s, b3_s;
  logic [5:0] d3_s;

  logic        iv8_s, ir8_s, ov8_s, or8_s, z8_s, busy8_s;
  logic [1:0]  op8_s;
  logic [7:0]  a8_s, b8_s;
  logic [15:0] d8_s;

  alu_seq #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3_s), .in_ready(ir3_s), .ALU_OP(op3_s),
    .A(a3_s), .B(b3_s), .out_valid(ov3_s), .out_ready(or3_s), .Dout(d3_s),
    .zero(z3_s), .busy(busy3_s)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8_s), .in_ready(ir8_s), .ALU_OP(op8_s),
    .A(a8_s), .B(b8_s), .out_valid(ov8_s), .out_ready(or8_s), .Dout(d8_s),
    .zero(z8_s), .busy(busy8_s)
  );

  // Reference ALU in plain integer arithmetic for a w-bit operand width.
  function automatic int ref_alu(input int w, input int op, input int a, input int b);
    int lo_mask;
    int full_mask;
    lo_mask   = (1 << w) - 1;
    full_mask = (1 << (2 * w)) - 1;
    case (op)
      0:       return (~(a ^ b)) & lo_mask;
      1:       return (((b << w) | a) << 1) & full_mask;
      2:       return a + b;
      default: return a * b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    checks++;
    if (ir3_s !== 1'b1 || ov3_s !== 1'b0 || d3_s !== 6'd0 || z3_s !== 1'b0 || busy3_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_w3: got ir=%b ov=%b d=%0d z=%b busy=%b, expected ir=1 ov=0 d=0 z=0 busy=0",
               ir3_s, ov3_s, d3_s, z3_s, busy3_s);
    end
    checks++;
    if (ir8_s !== 1'b1 || ov8_s !== 1'b0 || d8_s !== 16'd0 || z8_s !== 1'b0 || busy8_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_w8: got ir=%b ov=%b d=%0d z=%b busy=%b, expected ir=1 ov=0 d=0 z=0 busy=0",
               ir8_s, ov8_s, d8_s, z8_s, busy8_s);
    end
  endtask

  // One WIDTH=3 operation with out_ready held high; checks latency, result, zero and the handshake.
  task automatic run_op3(input string name, input logic [1:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic [5:0] exp_d, input int exp_lat);
    int n;
    int guard;
    or3_s = 1'b1;
    guard = 0;
    while (ir3_s !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    checks++;
    if (ir3_s !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got in_ready=%b, expected 1", name, ir3_s);
    end
    op3_s = op; a3_s = a; b3_s = b; iv3_s = 1'b1;
    step();
    iv3_s = 1'b0; a3_s = 3'($urandom); b3_s = 3'($urandom);
    n = 1;
    while (ov3_s !== 1'b1 && n < 20) begin
      checks++;
      if (ir3_s !== 1'b0 || busy3_s !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy: cycle %0d got in_ready=%b busy=%b, expected 0 and 1", name, n, ir3_s, busy3_s);
      end
      step();
      n++;
    end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d, expected %0d", name, n, exp_lat);
    end
    checks++;
    if (d3_s !== exp_d || z3_s !== (exp_d == 6'd0) || ir3_s !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: got Dout=%0d zero=%b in_ready=%b, expected Dout=%0d zero=%b in_ready=0",
               name, d3_s, z3_s, ir3_s, exp_d, (exp_d == 6'd0));
    end
    step();
    checks++;
    if (ov3_s !== 1'b0 || ir3_s !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake: got out_valid=%b in_ready=%b, expected 0 and 1", name, ov3_s, ir3_s);
    end
  endtask

  task automatic test_basic_ops();
    run_op3("xnor", 2'b00, 3'b101, 3'b011, 6'b000001, 1);
    run_op3("shift", 2'b01, 3'b101, 3'b100, 6'b001010, 1);
    run_op3("add", 2'b10, 3'd7, 3'd7, 6'd14, 1);
  endtask

  task automatic test_multiply();
    run_op3("mul_7x7", 2'b11, 3'd7, 3'd7, 6'd49, MUL_LAT3);
    run_op3("mul_5x0", 2'b11, 3'd5, 3'd0, 6'd0, MUL_LAT3);
  endtask

  task automatic test_backpressure();
    or3_s = 1'b0;
    op3_s = 2'b10; a3_s = 3'd3; b3_s = 3'd2; iv3_s = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ov3_s !== 1'b1 || d3_s !== 6'd5 || ir3_s !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d got ov=%b Dout=%0d ir=%b, expected ov=1 Dout=5 ir=0",
                 i, ov3_s, d3_s, ir3_s);
      end
      op3_s = 2'($urandom); a3_s = 3'($urandom); b3_s = 3'($urandom);
      step();
    end
    iv3_s = 1'b0;
    or3_s = 1'b1;
    step();
    checks++;
    if (ov3_s !== 1'b0 || ir3_s !== 1'b1 || d3_s !== 6'd5) begin
      errors++;
      $display("FAIL backpressure_release: got ov=%b ir=%b Dout=%0d, expected ov=0 ir=1 Dout=5",
               ov3_s, ir3_s, d3_s);
    end
  endtask

  task automatic test_reset_mid_mul();
    or3_s = 1'b0;
    op3_s = 2'b11; a3_s = 3'd6; b3_s = 3'd5; iv3_s = 1'b1;
    step();
    iv3_s = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (ov3_s !== 1'b0 || d3_s !== 6'd0 || busy3_s !== 1'b0 || ir3_s !== 1'b1 || z3_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mul: got ov=%b Dout=%0d busy=%b ir=%b z=%b, expected 0 0 0 1 0",
               ov3_s, d3_s, busy3_s, ir3_s, z3_s);
    end
    or3_s = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (ov3_s !== 1'b0 || d3_s === 6'd30) begin
        errors++;
        $display("FAIL reset_mid_mul_discard: cycle %0d got ov=%b Dout=%0d, expected ov=0 and no 30",
                 i, ov3_s, d3_s);
      end
    end
  endtask

  // Random valid/ready traffic on the WIDTH=8 instance, scored in order against ref_alu.
  task automatic test_random_sweep();
    int          exp_q[$];
    int          sent;
    int          received;
    int          cycles;
    logic [15:0] e;
    sent = 0; received = 0; cycles = 0;
    while (received < 1000 && cycles < 60000) begin
      iv8_s = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      op8_s = 2'($urandom);
      a8_s  = 8'($urandom);
      b8_s  = 8'($urandom);
      if ($urandom_range(0, 9) == 0) a8_s = 8'd0;
      or8_s = ($urandom_range(0, 3) != 0);
      if (iv8_s && ir8_s) begin
        exp_q.push_back(ref_alu(8, int'(op8_s), int'(a8_s), int'(b8_s)));
        sent++;
      end
      if (ov8_s && or8_s) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sweep_extra: got unexpected result Dout=%0d, expected none", d8_s);
        end else begin
          e = 16'(exp_q.pop_front());
          if (d8_s !== e || z8_s !== (e == 16'd0)) begin
            errors++;
            $display("FAIL sweep_result: op %0d got Dout=%0d zero=%b, expected Dout=%0d zero=%b",
                     received, d8_s, z8_s, e, (e == 16'd0));
          end
        end
        received++;
      end
      step();
      cycles++;
    end
    iv8_s = 1'b0;
    checks++;
    if (received != 1000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL sweep_count: got %0d results with %0d pending, expected 1000 and 0",
               received, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    iv3_s = 1'b0; or3_s = 1'b0; op3_s = 2'b00; a3_s = 3'd0; b3_s = 3'd0;
    iv8_s = 1'b0; or8_s = 1'b0; op8_s = 2'b00; a8_s = 8'd0; b8_s = 8'd0;
    test_reset();
    test_basic_ops();
    test_multiply();
    test_backpressure();
    test_reset_mid_mul();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
